// File: rtl/vwb_pkg.sv
// Shared types and constants for the vector-lane writeback arbiter.
// The request struct is the unit moved between exec input, skid buffer and write port.
package vwb_pkg;

  localparam int VWB_DATA_W = 64;
  localparam int VWB_REG_W  = 5;

  localparam logic [2:0] SEW_64 = 3'b011;

  typedef struct packed {
    logic [VWB_DATA_W-1:0] data;
    logic [VWB_REG_W-1:0]  dest;
    logic [2:0]            sew;
    logic                  masked;
  } wb_req_t;

endpackage

// File: rtl/vlane_writeback_arb_if.sv
// Bundle of load-issue, memory-response, exec-result and register-file write signals.
// master = execution pipe / load unit / register file side, slave = writeback arbiter.
interface vwb_if #(
  parameter int DATA_WIDTH   = 64,
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_Q_DEPTH = 4
);
  localparam int CNT_W = $clog2(LOAD_Q_DEPTH + 1);

  logic                  load_issue_valid;
  logic [REG_ADDR_W-1:0] load_issue_dest;
  logic                  load_issue_ready;
  logic                  mem_valid;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  ex_valid;
  logic                  ex_ready;
  logic [DATA_WIDTH-1:0] ex_data;
  logic [REG_ADDR_W-1:0] ex_dest;
  logic [2:0]            ex_sew;
  logic                  ex_masked;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [REG_ADDR_W-1:0] wr_dest;
  logic [2:0]            wr_sew;
  logic                  wr_masked;
  logic                  wr_from_load;
  logic                  read_done;
  logic [CNT_W-1:0]      loads_pending;
  logic                  err_orphan_resp;

  modport master (
    output load_issue_valid, load_issue_dest, mem_valid, mem_data,
           ex_valid, ex_data, ex_dest, ex_sew, ex_masked,
    input  load_issue_ready, ex_ready, wr_en, wr_data, wr_dest, wr_sew,
           wr_masked, wr_from_load, read_done, loads_pending, err_orphan_resp
  );

  modport slave (
    input  load_issue_valid, load_issue_dest, mem_valid, mem_data,
           ex_valid, ex_data, ex_dest, ex_sew, ex_masked,
    output load_issue_ready, ex_ready, wr_en, wr_data, wr_dest, wr_sew,
           wr_masked, wr_from_load, read_done, loads_pending, err_orphan_resp
  );
endinterface

// File: rtl/vwb_dest_fifo.sv
// Small FIFO holding destination registers of outstanding loads, oldest at the head.
// Caller guarantees no push when full and no pop when empty.
module vwb_dest_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // NOTE: storage has no reset; validity is tracked entirely by count_q and the pointers.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_i && !pop_i)      count_q <= count_q + 1'b1;
      else if (pop_i && !push_i) count_q <= count_q - 1'b1;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/vlane_writeback_arb.sv
// Writeback arbiter: memory responses beat the skid buffer, which beats new exec results.
// A displaced exec result parks in a one-entry skid buffer; writes are registered.
module vlane_writeback_arb
  import vwb_pkg::*;
#(
  parameter int DATA_WIDTH   = VWB_DATA_W,
  parameter int REG_ADDR_W   = VWB_REG_W,
  parameter int LOAD_Q_DEPTH = 4
) (
  input logic  clk,
  input logic  rst_n,
  vwb_if.slave bus
);

  localparam int CNT_W = $clog2(LOAD_Q_DEPTH + 1);

  logic                  q_push, q_pop, q_full, q_empty;
  logic [REG_ADDR_W-1:0] q_head;
  logic [CNT_W-1:0]      q_count;

  logic    load_win, ex_accept;
  wb_req_t ex_req;
  wb_req_t skid_q, skid_d, wr_req_q, wr_req_d;
  logic    skid_valid_q, skid_valid_d;
  logic    wr_en_q, wr_en_d;
  logic    wr_from_load_q, wr_from_load_d;
  logic    read_done_q, read_done_d;
  logic    err_orphan_q, err_orphan_d;

  // A response with nothing queued is dropped; a same-cycle issue still enqueues.
  assign load_win  = bus.mem_valid & ~q_empty;
  assign q_pop     = load_win;
  assign q_push    = bus.load_issue_valid & ~q_full;
  assign ex_accept = bus.ex_valid & ~skid_valid_q;
  assign ex_req    = '{data: bus.ex_data, dest: bus.ex_dest, sew: bus.ex_sew,
                       masked: bus.ex_masked};

  vwb_dest_fifo #(
    .DEPTH (LOAD_Q_DEPTH),
    .WIDTH (REG_ADDR_W)
  ) u_dest_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (q_push),
    .din_i   (bus.load_issue_dest),
    .pop_i   (q_pop),
    .head_o  (q_head),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    wr_en_d        = 1'b0;
    wr_req_d       = wr_req_q;
    wr_from_load_d = wr_from_load_q;
    read_done_d    = 1'b0;
    skid_valid_d   = skid_valid_q;
    skid_d         = skid_q;
    err_orphan_d   = err_orphan_q | (bus.mem_valid & q_empty);

    if (load_win) begin
      wr_en_d        = 1'b1;
      wr_req_d       = '{data: bus.mem_data, dest: q_head, sew: SEW_64, masked: 1'b0};
      wr_from_load_d = 1'b1;
      read_done_d    = 1'b1;
      if (ex_accept) begin
        skid_valid_d = 1'b1;
        skid_d       = ex_req;
      end
    end else if (skid_valid_q) begin
      wr_en_d        = 1'b1;
      wr_req_d       = skid_q;
      wr_from_load_d = 1'b0;
      skid_valid_d   = 1'b0;
    end else if (ex_accept) begin
      wr_en_d        = 1'b1;
      wr_req_d       = ex_req;
      wr_from_load_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q   <= 1'b0;
      skid_q         <= '0;
      wr_en_q        <= 1'b0;
      wr_req_q       <= '0;
      wr_from_load_q <= 1'b0;
      read_done_q    <= 1'b0;
      err_orphan_q   <= 1'b0;
    end else begin
      skid_valid_q   <= skid_valid_d;
      skid_q         <= skid_d;
      wr_en_q        <= wr_en_d;
      wr_req_q       <= wr_req_d;
      wr_from_load_q <= wr_from_load_d;
      read_done_q    <= read_done_d;
      err_orphan_q   <= err_orphan_d;
    end
  end

  assign bus.ex_ready         = ~skid_valid_q;
  assign bus.load_issue_ready = ~q_full;
  assign bus.wr_en            = wr_en_q;
  assign bus.wr_data          = wr_req_q.data;
  assign bus.wr_dest          = wr_req_q.dest;
  assign bus.wr_sew           = wr_req_q.sew;
  assign bus.wr_masked        = wr_req_q.masked;
  assign bus.wr_from_load     = wr_from_load_q;
  assign bus.read_done        = read_done_q;
  assign bus.loads_pending    = q_count;
  assign bus.err_orphan_resp  = err_orphan_q;

endmodule
